// File: rtl/output_argmax.sv
// output_argmax: sequential argmax over one vector of NO signed scores.
// A vector is taken on the AM handshake and scanned one element per cycle.
// The winning index and its score are then presented on the BM handshake.
// Optional feature macro: ARGMAX_HIT_COUNT_EN adds a label input and a
// saturating count of correct predictions.
module output_argmax #(
   parameter int unsigned NO = 2,
   parameter int unsigned WO = 11,
`ifdef ARGMAX_HIT_COUNT_EN
   parameter int unsigned WC = 16,
`endif
   localparam int unsigned WI = (NO > 1) ? $clog2(NO) : 1
)(
   input  logic             iCLK,
   input  logic             iRST,
   input  logic             iValid_AM_Output,
   output logic             oReady_AM_Output,
   input  logic [NO*WO-1:0] iData_AM_Output,
   output logic             oValid_BM_Class,
   input  logic             iReady_BM_Class,
   output logic [WI-1:0]    oData_BM_Class,
   output logic [WO-1:0]    oData_BM_Max
`ifdef ARGMAX_HIT_COUNT_EN
   ,
   input  logic [WI-1:0]    iData_AM_Label,
   output logic [WC-1:0]    oHitCount
`endif
);

   localparam int unsigned CW = WI + 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SCAN = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;

   logic [1:0]            state_q, state_d;
   logic [NO*WO-1:0]      vec_q, vec_d;
   logic signed [WO-1:0]  best_q, best_d;
   logic [WI-1:0]         idx_q, idx_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  ready_d, valid_d;
   logic [WI-1:0]         class_d;
   logic [WO-1:0]         max_d;

`ifdef ARGMAX_HIT_COUNT_EN
   logic [WI-1:0]         label_q, label_d;
   logic [WC-1:0]         hit_d;
`endif

   logic signed [WO-1:0]  elem [NO];
   logic signed [WO-1:0]  cur_elem;
   logic signed [WO-1:0]  in_elem0;
   logic                  cur_wins;
   logic signed [WO-1:0]  win_best;
   logic [WI-1:0]         win_idx;

   // Unpack the registered vector into individually addressable scores.
   for (genvar g = 0; g < NO; g++) begin : g_elem
      assign elem[g] = vec_q[g*WO +: WO];
   end

   assign in_elem0 = iData_AM_Output[WO-1:0];

   // Next-state and next-output logic; every target gets its hold value first.
   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      best_d  = best_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      ready_d = oReady_AM_Output;
      valid_d = oValid_BM_Class;
      class_d = oData_BM_Class;
      max_d   = oData_BM_Max;
`ifdef ARGMAX_HIT_COUNT_EN
      label_d = label_q;
      hit_d   = oHitCount;
`endif

      // Element currently addressed by the scan counter.
      cur_elem = '0;
      for (int unsigned i = 0; i < NO; i++) begin
         if (cnt_q == CW'(i)) cur_elem = elem[i];
      end

      // Strict greater-than keeps the earliest index on ties.
      cur_wins = (cur_elem > best_q);
      win_best = cur_wins ? cur_elem : best_q;
      win_idx  = cur_wins ? WI'(cnt_q) : idx_q;

      case (state_q)
         S_IDLE: begin
            ready_d = 1'b1;
            if (iValid_AM_Output && oReady_AM_Output) begin
               vec_d   = iData_AM_Output;
               best_d  = in_elem0;
               idx_d   = '0;
               cnt_d   = CW'(1);
               ready_d = 1'b0;
`ifdef ARGMAX_HIT_COUNT_EN
               label_d = iData_AM_Label;
`endif
               if (NO == 1) begin
                  // A single score is its own maximum; skip the scan.
                  state_d = S_HOLD;
                  valid_d = 1'b1;
                  class_d = '0;
                  max_d   = in_elem0;
               end else begin
                  state_d = S_SCAN;
               end
            end
         end

         S_SCAN: begin
            best_d = win_best;
            idx_d  = win_idx;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CW'(NO - 1)) begin
               state_d = S_HOLD;
               valid_d = 1'b1;
               class_d = win_idx;
               max_d   = win_best;
            end
         end

         S_HOLD: begin
            if (iReady_BM_Class) begin
               state_d = S_IDLE;
               valid_d = 1'b0;
               ready_d = 1'b1;
`ifdef ARGMAX_HIT_COUNT_EN
               // Saturating count of results that matched their label.
               if ((oData_BM_Class == label_q) && (oHitCount != {WC{1'b1}}))
                  hit_d = oHitCount + WC'(1);
`endif
            end
         end

         default: begin
            state_d = S_IDLE;
            ready_d = 1'b0;
            valid_d = 1'b0;
         end
      endcase
   end

   // State and registered outputs; reset aborts any scan in progress.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         state_q          <= S_IDLE;
         vec_q            <= '0;
         best_q           <= '0;
         idx_q            <= '0;
         cnt_q            <= '0;
         oReady_AM_Output <= 1'b0;
         oValid_BM_Class  <= 1'b0;
         oData_BM_Class   <= '0;
         oData_BM_Max     <= '0;
`ifdef ARGMAX_HIT_COUNT_EN
         label_q          <= '0;
         oHitCount        <= '0;
`endif
      end else begin
         state_q          <= state_d;
         vec_q            <= vec_d;
         best_q           <= best_d;
         idx_q            <= idx_d;
         cnt_q            <= cnt_d;
         oReady_AM_Output <= ready_d;
         oValid_BM_Class  <= valid_d;
         oData_BM_Class   <= class_d;
         oData_BM_Max     <= max_d;
`ifdef ARGMAX_HIT_COUNT_EN
         label_q          <= label_d;
         oHitCount        <= hit_d;
`endif
      end
   end

endmodule

// File: tb/tb_output_argmax.sv
// Bench for output_argmax: a 3-class and a 1-class instance checked
// against a plain argmax model. ARGMAX_HIT_COUNT_EN adds the hit-count test.
`timescale 1ns/1ps
module tb_output_argmax;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // 3-class instance
   logic        v3_i = 1'b0;
   logic [32:0] d3_i = '0;
   logic        rdy3_i = 1'b1;
   logic        r3_o, val3_o;
   logic [1:0]  cls3_o;
   logic [10:0] max3_o;

   // 1-class instance
   logic        v1_i = 1'b0;
   logic [10:0] d1_i = '0;
   logic        rdy1_i = 1'b1;
   logic        r1_o, val1_o;
   logic [0:0]  cls1_o;
   logic [10:0] max1_o;

`ifdef ARGMAX_HIT_COUNT_EN
   logic [1:0]  lbl3_i = '0;
   logic [1:0]  hit3_o;
   logic [0:0]  lbl1_i = '0;
   logic [15:0] hit1_o;
`endif

   output_argmax #(.NO(3), .WO(11)
`ifdef ARGMAX_HIT_COUNT_EN
      , .WC(2)
`endif
   ) dut3 (
      .iCLK(clk), .iRST(rst),
      .iValid_AM_Output(v3_i), .oReady_AM_Output(r3_o), .iData_AM_Output(d3_i),
      .oValid_BM_Class(val3_o), .iReady_BM_Class(rdy3_i),
      .oData_BM_Class(cls3_o), .oData_BM_Max(max3_o)
`ifdef ARGMAX_HIT_COUNT_EN
      , .iData_AM_Label(lbl3_i), .oHitCount(hit3_o)
`endif
   );

   output_argmax #(.NO(1), .WO(11)) dut1 (
      .iCLK(clk), .iRST(rst),
      .iValid_AM_Output(v1_i), .oReady_AM_Output(r1_o), .iData_AM_Output(d1_i),
      .oValid_BM_Class(val1_o), .iReady_BM_Class(rdy1_i),
      .oData_BM_Class(cls1_o), .oData_BM_Max(max1_o)
`ifdef ARGMAX_HIT_COUNT_EN
      , .iData_AM_Label(lbl1_i), .oHitCount(hit1_o)
`endif
   );

   int n_cmp = 0;
   int n_bad = 0;
   int hs_cyc = 0;

   // Reference: index of first maximum over a list of integers.
   function automatic void ref_argmax(input int v[$], output int idx, output int mx);
      idx = 0;
      mx  = v[0];
      foreach (v[i]) if (v[i] > mx) begin mx = v[i]; idx = i; end
   endfunction

   function automatic int rnd_score(input int wide);
      if (wide != 0) return int'($urandom_range(0, 2047)) - 1024;
      return int'($urandom_range(0, 4)) - 2;
   endfunction

   // Wait (bounded) for dut3 ready at a falling edge.
   task automatic wait_ready3(input string name);
      int guard = 0;
      while (!r3_o && guard < 20) begin @(negedge clk); guard++; end
      if (!r3_o) begin
         n_cmp++; n_bad++;
         $display("FAIL %s: ready timeout, got %0b required 1", name, r3_o);
      end
   endtask

   // Push one vector into dut3 with downstream ready high and check the result.
   task automatic send3(input int a0, input int a1, input int a2, input int lbl, input string name);
      int q[$];
      int eidx, emax;
      logic [10:0] emx;
      q = '{a0, a1, a2};
      ref_argmax(q, eidx, emax);
      emx = 11'(emax);
      wait_ready3(name);
      v3_i = 1'b1;
      d3_i = {11'(a2), 11'(a1), 11'(a0)};
`ifdef ARGMAX_HIT_COUNT_EN
      lbl3_i = 2'(lbl);
`else
      if (lbl < 0) $display("note: negative label ignored");
`endif
      @(negedge clk);
      hs_cyc = cyc;
      v3_i = 1'b0;
      d3_i = {$urandom, $urandom};
      n_cmp++;
      if (r3_o !== 1'b0) begin n_bad++; $display("FAIL %s ready_drop: got %0b required 0", name, r3_o); end
      for (int k = 1; k < 3; k++) begin
         n_cmp++;
         if (val3_o !== 1'b0) begin n_bad++; $display("FAIL %s early_valid k=%0d: got %0b required 0", name, k, val3_o); end
         @(negedge clk);
      end
      n_cmp++;
      if (val3_o !== 1'b1) begin n_bad++; $display("FAIL %s valid: got %0b required 1", name, val3_o); end
      n_cmp++;
      if (cls3_o !== 2'(eidx)) begin n_bad++; $display("FAIL %s class: got %0d required %0d", name, cls3_o, eidx); end
      n_cmp++;
      if (max3_o !== emx) begin n_bad++; $display("FAIL %s max: got %0d required %0d", name, $signed(max3_o), emax); end
      @(negedge clk);
      n_cmp++;
      if (val3_o !== 1'b0 || r3_o !== 1'b1) begin
         n_bad++; $display("FAIL %s release: got valid=%0b ready=%0b required valid=0 ready=1", name, val3_o, r3_o);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({r3_o, val3_o, cls3_o, max3_o, r1_o, val1_o, cls1_o, max1_o} !== '0) begin
         n_bad++; $display("FAIL reset_outputs: got %h required 0", {r3_o, val3_o, cls3_o, max3_o, r1_o, val1_o, cls1_o, max1_o});
      end
`ifdef ARGMAX_HIT_COUNT_EN
      n_cmp++;
      if (hit3_o !== 2'd0) begin n_bad++; $display("FAIL reset_hit: got %0d required 0", hit3_o); end
`endif
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_cmp++;
      if (r3_o !== 1'b0) begin n_bad++; $display("FAIL reset_ready_before_edge: got %0b required 0", r3_o); end
      @(negedge clk);
      n_cmp++;
      if (r3_o !== 1'b1 || r1_o !== 1'b1) begin n_bad++; $display("FAIL reset_ready_after_edge: got %0b%0b required 11", r3_o, r1_o); end
   endtask

   task automatic test_directed();
      send3(5, -3, 9, 2, "vec_5_m3_9");
      send3(7, 7, -1, 0, "tie_7_7_m1");
      send3(-4, -2, -9, 1, "neg_m4_m2_m9");
      send3(-1024, -1024, -1024, 0, "all_min");
      send3(1023, -1024, 1023, 0, "max_tie_ends");
   endtask

   task automatic test_random();
      for (int n = 0; n < 24; n++) begin
         int w = (n % 3 != 0) ? 1 : 0;
         send3(rnd_score(w), rnd_score(w), rnd_score(w), 0, "random");
      end
   endtask

   task automatic test_back_to_back();
      int prev;
      send3(1, 2, 3, 2, "b2b_0");
      prev = hs_cyc;
      for (int n = 1; n < 4; n++) begin
         send3(rnd_score(1), rnd_score(1), rnd_score(1), 0, "b2b");
         n_cmp++;
         if (hs_cyc - prev !== 4) begin n_bad++; $display("FAIL b2b_interval: got %0d required 4", hs_cyc - prev); end
         prev = hs_cyc;
      end
   endtask

   task automatic test_backpressure();
      int guard = 0;
      rdy3_i = 1'b0;
      wait_ready3("bp_a");
      v3_i = 1'b1;
      d3_i = {11'sd3, 11'sd8, -11'sd2};
      @(negedge clk);
      // Offer B while busy; it must be held off until the result is consumed.
      d3_i = {11'sd2, 11'sd6, 11'sd1};
      while (!val3_o && guard < 10) begin @(negedge clk); guard++; end
      for (int k = 0; k < 10; k++) begin
         n_cmp++;
         if (val3_o !== 1'b1 || cls3_o !== 2'd1 || max3_o !== 11'd8 || r3_o !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_hold k=%0d: got v=%0b c=%0d m=%0d r=%0b required v=1 c=1 m=8 r=0", k, val3_o, cls3_o, $signed(max3_o), r3_o);
         end
         @(negedge clk);
      end
      rdy3_i = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (val3_o !== 1'b0 || r3_o !== 1'b1) begin n_bad++; $display("FAIL bp_release: got v=%0b r=%0b required v=0 r=1", val3_o, r3_o); end
      @(negedge clk);
      v3_i = 1'b0;
      n_cmp++;
      if (r3_o !== 1'b0) begin n_bad++; $display("FAIL bp_accept_next: got ready=%0b required 0", r3_o); end
      @(negedge clk);
      @(negedge clk);
      n_cmp++;
      if (val3_o !== 1'b1 || cls3_o !== 2'd1 || max3_o !== 11'd6) begin
         n_bad++; $display("FAIL bp_vec_b: got v=%0b c=%0d m=%0d required v=1 c=1 m=6", val3_o, cls3_o, $signed(max3_o));
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_scan();
      wait_ready3("rst_scan");
      v3_i = 1'b1;
      d3_i = {11'sd4, 11'sd9, 11'sd1};
      @(negedge clk);
      v3_i = 1'b0;
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({r3_o, val3_o, cls3_o, max3_o} !== '0) begin
         n_bad++; $display("FAIL rst_scan_outputs: got %h required 0", {r3_o, val3_o, cls3_o, max3_o});
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_cmp++;
      if (r3_o !== 1'b0) begin n_bad++; $display("FAIL rst_scan_ready_early: got %0b required 0", r3_o); end
      @(negedge clk);
      n_cmp++;
      if (r3_o !== 1'b1 || val3_o !== 1'b0) begin n_bad++; $display("FAIL rst_scan_ready: got r=%0b v=%0b required r=1 v=0", r3_o, val3_o); end
      @(negedge clk);
      n_cmp++;
      if (val3_o !== 1'b0) begin n_bad++; $display("FAIL rst_scan_aborted: got valid=%0b required 0", val3_o); end
      send3(1, 2, 0, 1, "after_reset_1_2_0");
   endtask

   task automatic test_single_class();
      for (int n = 0; n < 4; n++) begin
         int s = (n == 0) ? -5 : rnd_score(1);
         int guard = 0;
         while (!r1_o && guard < 10) begin @(negedge clk); guard++; end
         v1_i = 1'b1;
         d1_i = 11'(s);
         @(negedge clk);
         v1_i = 1'b0;
         d1_i = 11'($urandom);
         n_cmp++;
         if (val1_o !== 1'b1 || cls1_o !== 1'b0 || max1_o !== 11'(s) || r1_o !== 1'b0) begin
            n_bad++; $display("FAIL no1 n=%0d: got v=%0b c=%0d m=%0d r=%0b required v=1 c=0 m=%0d r=0", n, val1_o, cls1_o, $signed(max1_o), r1_o, s);
         end
         @(negedge clk);
         n_cmp++;
         if (val1_o !== 1'b0 || r1_o !== 1'b1 || max1_o !== 11'(s)) begin
            n_bad++; $display("FAIL no1_release n=%0d: got v=%0b r=%0b m=%0d required v=0 r=1 m=%0d", n, val1_o, r1_o, $signed(max1_o), s);
         end
      end
   endtask

`ifdef ARGMAX_HIT_COUNT_EN
   task automatic test_hit_count();
      int exp_hit = 0;
      test_reset();
      send3(1, 5, 2, 0, "hit_mismatch");
      n_cmp++;
      if (hit3_o !== 2'd0) begin n_bad++; $display("FAIL hit_mismatch: got %0d required 0", hit3_o); end
      for (int n = 0; n < 5; n++) begin
         int q[$];
         int idx, mx;
         q = '{rnd_score(1), rnd_score(1), rnd_score(1)};
         ref_argmax(q, idx, mx);
         send3(q[0], q[1], q[2], idx, "hit_match");
         if (exp_hit < 3) exp_hit++;
         n_cmp++;
         if (hit3_o !== 2'(exp_hit)) begin n_bad++; $display("FAIL hit_count n=%0d: got %0d required %0d", n, hit3_o, exp_hit); end
      end
      send3(9, 1, 2, 2, "hit_sat_mismatch");
      n_cmp++;
      if (hit3_o !== 2'd3) begin n_bad++; $display("FAIL hit_sat_mismatch: got %0d required 3", hit3_o); end
   endtask
`endif

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_backpressure();
      test_reset_mid_scan();
      test_single_class();
`ifdef ARGMAX_HIT_COUNT_EN
      test_hit_count();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
